nonce_report_tx: RTL and testbench

- Downstream companion of the UART command/response block. Turns golden nonces from the hashing core into NONCE_FOUND response frames on the outgoing UART byte stream.
- Buffers nonces in a small FIFO and serialises one 12-byte frame per nonce, appending a CRC32.
- Single clock domain (comm_clk). The caller synchronises rx_new_nonce/rx_golden_nonce into comm_clk before this block.

---
 rtl/nonce_report_tx.sv | 191 +++++++++++++++++++
 tb/tb_nonce_report_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/nonce_report_tx.sv
// Nonce report transmitter: queues golden nonces and serialises each as a
// 12-byte NONCE_FOUND frame (header, nonce, reflected CRC-32) onto the UART TX byte stream.
module nonce_report_tx #(
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [7:0]  MSG_NONCE_FOUND = 8'd6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        nonce_we,
  input  logic [31:0] nonce,
  input  logic        tx_ready,
  output logic        tx_we,
  output logic [7:0]  tx_data,
  output logic        frame_active,
  output logic [6:0]  fifo_count,
  output logic [7:0]  drop_count
);

  localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [3:0]  LAST_IDX = 4'd11;

  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_e;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [31:0] n,
                                            input logic [31:0] crc);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h0C;
      4'd1:    b = 8'h00;
      4'd2:    b = 8'h00;
      4'd3:    b = MSG_NONCE_FOUND;
      4'd4:    b = n[7:0];
      4'd5:    b = n[15:8];
      4'd6:    b = n[23:16];
      4'd7:    b = n[31:24];
      4'd8:    b = crc[7:0];
      4'd9:    b = crc[15:8];
      4'd10:   b = crc[23:16];
      4'd11:   b = crc[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [6:0]    count_q, count_d;
  logic [7:0]    drop_q, drop_d;
  state_e        state_q, state_d;
  logic [31:0]   nonce_q, nonce_d;
  logic [31:0]   crc_q, crc_d;
  logic [3:0]    idx_q, idx_d;
  logic          tx_we_q, tx_we_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          frame_active_q, frame_active_d;
  logic          full_s, pop_s, push_s, drop_s;
  logic [7:0]    byte_s;

  // A pop frees a slot in the same edge, so a push onto a full FIFO being popped is kept.
  always_comb begin
    full_s = (count_q == 7'(FIFO_DEPTH));
    pop_s  = (state_q == ST_IDLE) && (count_q != 7'd0);
    push_s = nonce_we && (!full_s || pop_s);
    drop_s = nonce_we && full_s && !pop_s;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 7'd1;
      2'b01:   count_d = count_q - 7'd1;
      default: count_d = count_q;
    endcase
    if (drop_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= nonce;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 7'd0;
      drop_q   <= 8'd0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) state_d = ST_SEND;
        else       state_d = ST_IDLE;
      end
      ST_SEND: begin
        if (tx_ready && (idx_q == LAST_IDX)) state_d = ST_IDLE;
        else                                 state_d = ST_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // CRC only folds bytes 0-7; bytes 8-11 read the then-frozen CRC register.
  always_comb begin
    tx_we_d        = 1'b0;
    tx_data_d      = tx_data_q;
    nonce_d        = nonce_q;
    crc_d          = crc_q;
    idx_d          = idx_q;
    frame_active_d = 1'b0;
    byte_s         = frame_byte(idx_q, nonce_q, crc_q);
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          nonce_d        = mem_q[rd_ptr_q];
          crc_d          = CRC_INIT;
          idx_d          = 4'd0;
          frame_active_d = 1'b1;
        end else begin
          frame_active_d = 1'b0;
        end
      end
      ST_SEND: begin
        frame_active_d = 1'b1;
        if (tx_ready) begin
          tx_we_d   = 1'b1;
          tx_data_d = byte_s;
          idx_d     = idx_q + 4'd1;
          if (idx_q < 4'd8) crc_d = crc32_byte(crc_q, byte_s);
          else              crc_d = crc_q;
        end else begin
          tx_we_d = 1'b0;
        end
      end
      default: frame_active_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_we_q        <= 1'b0;
      tx_data_q      <= 8'd0;
      frame_active_q <= 1'b0;
      nonce_q        <= 32'd0;
      crc_q          <= CRC_INIT;
      idx_q          <= 4'd0;
    end else begin
      tx_we_q        <= tx_we_d;
      tx_data_q      <= tx_data_d;
      frame_active_q <= frame_active_d;
      nonce_q        <= nonce_d;
      crc_q          <= crc_d;
      idx_q          <= idx_d;
    end
  end

  assign tx_we        = tx_we_q;
  assign tx_data      = tx_data_q;
  assign frame_active = frame_active_q;
  assign fifo_count   = count_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_nonce_report_tx.sv
// Directed testbench for nonce_report_tx: frame content, CRC residue, latency,
// backpressure, overflow, drop saturation, mid-frame reset and push/pop on full.
module tb_nonce_report_tx;
  logic        clk = 1'b0;
  logic        reset_n, nonce_we, tx_ready;
  logic [31:0] nonce;
  logic        tx_we, frame_active;
  logic [7:0]  tx_data, drop_count;
  logic [6:0]  fifo_count;

  int tests = 0;
  int fails = 0;

  logic [7:0] got[$];
  logic [7:0] exp[$];
  int cyc, first_we, last_we, fa_cycles, ready_viol;

  nonce_report_tx #(.FIFO_DEPTH(8), .MSG_NONCE_FOUND(8'd6)) dut (
    .clk(clk), .reset_n(reset_n), .nonce_we(nonce_we), .nonce(nonce), .tx_ready(tx_ready),
    .tx_we(tx_we), .tx_data(tx_data), .frame_active(frame_active),
    .fifo_count(fifo_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_crc(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'd0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  task automatic add_exp(input logic [31:0] n);
    logic [7:0]  b[8];
    logic [31:0] c;
    b[0] = 8'h0C; b[1] = 8'h00; b[2] = 8'h00; b[3] = 8'h06;
    b[4] = n[7:0]; b[5] = n[15:8]; b[6] = n[23:16]; b[7] = n[31:24];
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 8; i++) begin
      c = ref_crc(c, b[i]);
      exp.push_back(b[i]);
    end
    for (int i = 0; i < 4; i++) exp.push_back(c[8*i +: 8]);
  endtask

  task automatic clear_mon();
    got.delete(); exp.delete();
    cyc = 0; first_we = -1; last_we = -1; fa_cycles = 0; ready_viol = 0;
  endtask

  // Advance cycles, recording emitted bytes; optional tx_ready pattern 1,0,0,1,0,0...
  task automatic drain(input int cycles, input bit toggle);
    logic prev;
    for (int c = 0; c < cycles; c++) begin
      prev = tx_ready;
      @(posedge clk); #1;
      cyc++;
      if (tx_we) begin
        got.push_back(tx_data);
        if (!prev) ready_viol++;
        if (first_we < 0) first_we = cyc;
        last_we = cyc;
      end
      if (frame_active) fa_cycles++;
      if (toggle) tx_ready = ((c + 1) % 3 == 0);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; nonce_we = 1'b0; tx_ready = 1'b0; nonce = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    clear_mon();
  endtask

  task automatic push_one(input logic [31:0] n);
    nonce = n; nonce_we = 1'b1;
    drain(1, 1'b0);
    nonce_we = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (tx_we !== 1'b0) begin fails++; $display("FAIL reset_tx_we got %b want 0", tx_we); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    tests++; if (frame_active !== 1'b0) begin fails++; $display("FAIL reset_frame_active got %b want 0", frame_active); end
    tests++; if (fifo_count !== 7'd0) begin fails++; $display("FAIL reset_fifo_count got %0d want 0", fifo_count); end
    tests++; if (drop_count !== 8'd0) begin fails++; $display("FAIL reset_drop_count got %0d want 0", drop_count); end
  endtask

  task automatic test_single();
    logic [31:0] c;
    do_reset();
    tx_ready = 1'b1;
    push_one(32'h12345678);
    drain(20, 1'b0);
    add_exp(32'h12345678);
    tests++; if (got.size() != 12) begin fails++; $display("FAIL single_len got %0d want 12", got.size()); end
    for (int i = 0; i < 12 && i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp[i]) begin fails++; $display("FAIL single_byte%0d got %h want %h", i, got[i], exp[i]); end
    end
    c = 32'hFFFFFFFF;
    foreach (got[i]) c = ref_crc(c, got[i]);
    tests++; if (c !== 32'h0) begin fails++; $display("FAIL single_crc_residue got %h want 00000000", c); end
    tests++; if (first_we - 1 != 2) begin fails++; $display("FAIL single_first_latency got %0d want 2", first_we - 1); end
    tests++; if (last_we - 1 != 13) begin fails++; $display("FAIL single_last_latency got %0d want 13", last_we - 1); end
    tests++; if (fa_cycles != 13) begin fails++; $display("FAIL single_frame_active_cycles got %0d want 13", fa_cycles); end
  endtask

  task automatic test_backpressure();
    do_reset();
    push_one(32'hDEADBEEF);
    tx_ready = 1'b1;
    drain(60, 1'b1);
    add_exp(32'hDEADBEEF);
    tests++; if (got.size() != 12) begin fails++; $display("FAIL bp_len got %0d want 12", got.size()); end
    for (int i = 0; i < 12 && i < got.size(); i++) begin
      tests++;
      if (got[i] !== exp[i]) begin fails++; $display("FAIL bp_byte%0d got %h want %h", i, got[i], exp[i]); end
    end
    tests++; if (ready_viol != 0) begin fails++; $display("FAIL bp_we_without_ready got %0d want 0", ready_viol); end
  endtask

  task automatic test_overflow();
    int bad;
    do_reset();
    for (int i = 0; i < 10; i++) push_one(32'hA000_0000 + 32'(i));
    // One nonce sits in the frame register, eight fill the FIFO, the tenth is dropped.
    tests++; if (fifo_count !== 7'd8) begin fails++; $display("FAIL ovf_fifo_count got %0d want 8", fifo_count); end
    tests++; if (drop_count !== 8'd1) begin fails++; $display("FAIL ovf_drop_count got %0d want 1", drop_count); end
    tx_ready = 1'b1;
    drain(140, 1'b0);
    for (int i = 0; i < 9; i++) add_exp(32'hA000_0000 + 32'(i));
    tests++; if (got.size() != 108) begin fails++; $display("FAIL ovf_len got %0d want 108", got.size()); end
    bad = 0;
    for (int i = 0; i < 108 && i < got.size(); i++) if (got[i] !== exp[i]) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL ovf_order got %0d bad bytes want 0", bad); end
    tests++; if (fifo_count !== 7'd0) begin fails++; $display("FAIL ovf_empty got %0d want 0", fifo_count); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      push_one(32'(i));
      if (i == 99) begin
        tests++; if (drop_count !== 8'd91) begin fails++; $display("FAIL sat_drop_100 got %0d want 91", drop_count); end
      end
    end
    tests++; if (drop_count !== 8'd255) begin fails++; $display("FAIL sat_drop got %0d want 255", drop_count); end
    tests++; if (fifo_count !== 7'd8) begin fails++; $display("FAIL sat_fifo_count got %0d want 8", fifo_count); end
  endtask

  task automatic test_reset_mid_frame();
    int budget;
    do_reset();
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_one(32'hC0DE_0000 + 32'(i));
    budget = 30;
    while (got.size() < 6 && budget > 0) begin drain(1, 1'b0); budget--; end
    tests++; if (got.size() != 6) begin fails++; $display("FAIL rmf_reach_byte5 got %0d bytes want 6", got.size()); end
    tests++; if (fifo_count !== 7'd3) begin fails++; $display("FAIL rmf_queued got %0d want 3", fifo_count); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    tests++; if (tx_we !== 1'b0) begin fails++; $display("FAIL rmf_tx_we got %b want 0", tx_we); end
    tests++; if (fifo_count !== 7'd0) begin fails++; $display("FAIL rmf_fifo_count got %0d want 0", fifo_count); end
    tests++; if (drop_count !== 8'd0) begin fails++; $display("FAIL rmf_drop_count got %0d want 0", drop_count); end
    tests++; if (frame_active !== 1'b0) begin fails++; $display("FAIL rmf_frame_active got %b want 0", frame_active); end
    reset_n = 1'b1;
    clear_mon();
    drain(40, 1'b0);
    tests++; if (got.size() != 0) begin fails++; $display("FAIL rmf_silent got %0d bytes want 0", got.size()); end
    tests++; if (fa_cycles != 0) begin fails++; $display("FAIL rmf_no_frame got %0d active cycles want 0", fa_cycles); end
  endtask

  task automatic test_push_pop_full();
    int budget;
    do_reset();
    for (int i = 0; i < 9; i++) push_one(32'hF000_0000 + 32'(i));
    tests++; if (fifo_count !== 7'd8) begin fails++; $display("FAIL ppf_full got %0d want 8", fifo_count); end
    tx_ready = 1'b1;
    budget = 30;
    while (got.size() < 12 && budget > 0) begin drain(1, 1'b0); budget--; end
    tests++; if (got.size() != 12) begin fails++; $display("FAIL ppf_first_frame got %0d bytes want 12", got.size()); end
    // FSM is IDLE now and pops on the next edge; push in that same edge.
    push_one(32'hF000_00FF);
    tests++; if (fifo_count !== 7'd8) begin fails++; $display("FAIL ppf_fifo_count got %0d want 8", fifo_count); end
    tests++; if (drop_count !== 8'd0) begin fails++; $display("FAIL ppf_drop_count got %0d want 0", drop_count); end
    tests++; if (frame_active !== 1'b1) begin fails++; $display("FAIL ppf_next_frame got %b want 1", frame_active); end
  endtask

  initial begin
    reset_n = 1'b0; nonce_we = 1'b0; tx_ready = 1'b0; nonce = 32'd0;
    clear_mon();
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_saturation();
    test_reset_mid_frame();
    test_push_pop_full();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
